// File: rtl/fx_noise_gate_if.sv
// Sample stream between the ADC path and the noise gate, plus the gate status.
interface fx_noise_gate_if;
  logic               i_valid;
  logic signed [15:0] i_sample;
  logic [2:0]         i_level;
  logic               o_valid;
  logic signed [15:0] o_sample;
  logic               o_gate_open;

  modport master (
    output i_valid, i_sample, i_level,
    input  o_valid, o_sample, o_gate_open
  );

  modport slave (
    input  i_valid, i_sample, i_level,
    output o_valid, o_sample, o_gate_open
  );
endinterface

// File: rtl/fx_noise_gate.sv
// Noise gate: peak envelope follower, open/close hysteresis, hold timer and linear gain ramps.
// Level 0 bypasses the gate; 1..7 select the open threshold.
module fx_noise_gate #(
  parameter int unsigned THRESH_STEP  = 256,
  parameter int unsigned DECAY_SHIFT  = 8,
  parameter logic [15:0] ATTACK_STEP  = 16'h0400,
  parameter logic [15:0] RELEASE_STEP = 16'h0040,
  parameter int unsigned HOLD_SAMPLES = 2048
) (
  input logic               i_clk,
  input logic               i_rst,
  fx_noise_gate_if.slave    bus
);

  localparam logic [15:0] GainUnity = 16'h8000;
  localparam logic [15:0] HoldInit  = 16'(HOLD_SAMPLES - 1);

  typedef enum logic [2:0] {StClosed, StAttack, StOpen, StHold, StRelease} state_e;

  state_e             state_q, state_d;
  logic [15:0]        gain_q, gain_d;
  logic [15:0]        env_q, env_d;
  logic [15:0]        hold_q, hold_d;
  logic               o_valid_q;
  logic signed [15:0] o_sample_q;
  logic               o_gate_q, gate_d;

  logic [15:0]        abs_val, decay_raw, decay, env_next;
  logic [15:0]        th_open, th_close;
  logic [16:0]        gain_up;
  logic signed [32:0] prod;
  logic signed [15:0] gated;

  // -32768 has no positive twin; clamp it so the magnitude stays within 15 bits.
  assign abs_val   = (bus.i_sample == 16'sh8000) ? 16'h7fff :
                     bus.i_sample[15] ? ($unsigned(~bus.i_sample) + 16'd1) :
                     $unsigned(bus.i_sample);
  assign decay_raw = env_q >> DECAY_SHIFT;
  assign decay     = (decay_raw == 16'd0) ? 16'd1 : decay_raw;
  // decay never exceeds env_q when env_q > 0, and abs >= 0 covers env_q == 0.
  assign env_next  = (abs_val >= env_q) ? abs_val : (env_q - decay);
  assign th_open   = 16'(bus.i_level) * 16'(THRESH_STEP);
  assign th_close  = th_open - (th_open >> 2);
  assign gain_up   = {1'b0, gain_q} + {1'b0, ATTACK_STEP};
  // Output uses the gain held before this sample's update.
  assign prod      = bus.i_sample * $signed({1'b0, gain_q});
  assign gated     = 16'(prod >>> 15);

  // Next-state, envelope, gain and hold counter; everything holds unless a sample arrives.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    env_d   = env_q;
    hold_d  = hold_q;
    if (bus.i_valid) begin
      env_d = env_next;
      if (bus.i_level == 3'd0) begin
        state_d = StOpen;
        gain_d  = GainUnity;
      end else begin
        case (state_q)
          StClosed: begin
            gain_d = '0;
            if (env_next >= th_open) state_d = StAttack;
          end
          StAttack: begin
            if (env_next < th_close) begin
              state_d = StRelease;
            end else if (gain_up >= {1'b0, GainUnity}) begin
              state_d = StOpen;
              gain_d  = GainUnity;
            end else begin
              gain_d = gain_up[15:0];
            end
          end
          StOpen: begin
            gain_d = GainUnity;
            if (env_next < th_close) begin
              state_d = StHold;
              hold_d  = HoldInit;
            end
          end
          StHold: begin
            if (env_next >= th_open) begin
              state_d = StOpen;
            end else if (hold_q == 16'd0) begin
              state_d = StRelease;
            end else begin
              hold_d = hold_q - 16'd1;
            end
          end
          StRelease: begin
            // Re-attack ramps up from the current gain rather than restarting at 0.
            if (env_next >= th_open) begin
              state_d = StAttack;
            end else if (gain_q <= RELEASE_STEP) begin
              state_d = StClosed;
              gain_d  = '0;
            end else begin
              gain_d = gain_q - RELEASE_STEP;
            end
          end
          default: begin
            state_d = StClosed;
            gain_d  = '0;
          end
        endcase
      end
    end
  end

  // Gate status reflects the state this sample leaves the FSM in.
  always_comb begin
    gate_d = (bus.i_level == 3'd0) ||
             (state_d == StAttack) || (state_d == StOpen) || (state_d == StHold);
  end

  // State registers and registered outputs; reset overrides a simultaneous sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StClosed;
      gain_q     <= '0;
      env_q      <= '0;
      hold_q     <= '0;
      o_valid_q  <= 1'b0;
      o_sample_q <= '0;
      o_gate_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gain_q    <= gain_d;
      env_q     <= env_d;
      hold_q    <= hold_d;
      o_valid_q <= bus.i_valid;
      if (bus.i_valid) begin
        o_sample_q <= (bus.i_level == 3'd0) ? bus.i_sample : gated;
        o_gate_q   <= gate_d;
      end
    end
  end

  assign bus.o_valid     = o_valid_q;
  assign bus.o_sample    = o_sample_q;
  assign bus.o_gate_open = o_gate_q;

endmodule
